// File: rtl/x_dl_pkg.sv
// Shared types and constants for the delay-line sampler.
package x_dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SAMPLE,
    ACC,
    DONE
  } state_t;

  localparam logic [1:0] SEL_SUM  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_MAX  = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  // Width needed to hold any code from 0 up to and including TAPS.
  function automatic int code_width(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/x_therm_enc.sv
// Combinational tap-snapshot encoder: leading run of taps matching the launch level,
// or popcount of matching taps when X_DL_BUBBLE_FILTER_EN is defined.
module x_therm_enc
  import x_dl_pkg::*;
#(
  parameter int TAPS = 64,
  parameter int CW   = code_width(TAPS)
) (
  input  logic [TAPS-1:0] snap,
  input  logic            level,
  output logic [CW-1:0]   code
);

`ifdef X_DL_BUBBLE_FILTER_EN
  always_comb begin
    code = '0;
    for (int i = 0; i < TAPS; i++) begin
      code = code + {{(CW-1){1'b0}}, snap[i] ~^ level};
    end
  end
`else
  logic run;

  // The run ends at the first tap that has not yet seen the new edge.
  always_comb begin
    code = '0;
    run  = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      if (run && (snap[i] == level)) begin
        code = CW'(i + 1);
      end else begin
        run = 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/x_dl_sampler.sv
// Delay-line sampler: launches edges, snapshots taps after SETTLE cycles and accumulates
// sum/min/max of the encoded codes over 2^LOG_SAMPLES samples (encoder honours X_DL_BUBBLE_FILTER_EN).
module x_dl_sampler
  import x_dl_pkg::*;
#(
  parameter int TAPS        = 64,
  parameter int LOG_SAMPLES = 8,
  parameter int SETTLE      = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_sel,
  input  logic [TAPS-1:0] i_taps,
  output logic            o_launch,
  output logic            o_busy,
  output logic            o_done,
  output logic [31:0]     o_data
);

  localparam int CW = code_width(TAPS);
  localparam int SW = CW + LOG_SAMPLES;
  localparam int NW = (LOG_SAMPLES > 0) ? LOG_SAMPLES : 1;
  localparam int WW = $clog2(SETTLE + 1);
  localparam logic [NW-1:0] LAST_IDX = NW'((1 << LOG_SAMPLES) - 1);

  if (SW > 32) begin : g_sw_check
    $error("x_dl_sampler: sum width exceeds 32 bits");
  end

  state_t          state;
  logic [TAPS-1:0] snap;
  logic [NW-1:0]   cnt;
  logic [WW-1:0]   wcnt;
  logic [SW-1:0]   sum;
  logic [CW-1:0]   min_c;
  logic [CW-1:0]   max_c;
  logic [CW-1:0]   last;
  logic [CW-1:0]   code;

  x_therm_enc #(
    .TAPS (TAPS),
    .CW   (CW)
  ) u_enc (
    .snap  (snap),
    .level (o_launch),
    .code  (code)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_launch <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      snap     <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      sum      <= '0;
      min_c    <= '0;
      max_c    <= '0;
      last     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cnt    <= '0;
            sum    <= '0;
            min_c  <= '1;
            max_c  <= '0;
            o_busy <= 1'b1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          o_launch <= ~o_launch;
          wcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wcnt == WW'(SETTLE - 1)) begin
            state <= SAMPLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        SAMPLE: begin
          snap  <= i_taps;
          state <= ACC;
        end
        ACC: begin
          sum  <= sum + SW'(code);
          last <= code;
          if (code < min_c) min_c <= code;
          if (code > max_c) max_c <= code;
          if (cnt == LAST_IDX) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end else begin
            cnt   <= cnt + NW'(1);
            state <= LAUNCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_data = '0;
    case (i_sel)
      SEL_SUM: o_data = 32'(sum);
      SEL_MIN: o_data = 32'(min_c);
      SEL_MAX: o_data = 32'(max_c);
      default: o_data = {o_busy, {(31-CW){1'b0}}, last};
    endcase
  end

endmodule

// File: tb/tb_x_dl_sampler.sv
// Self-checking bench for x_dl_sampler with TAPS=8, LOG_SAMPLES=2, SETTLE=1.
module tb_x_dl_sampler;

  localparam int TAPS   = 8;
  localparam int LOGS   = 2;
  localparam int SETTLE = 1;
  localparam int N      = 1 << LOGS;
  localparam int P      = SETTLE + 3;
  localparam int LAT    = 1 + N * P;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_sel;
  logic [7:0]  i_taps;
  logic        o_launch;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_data;

  int pass_cnt = 0;
  int total    = 0;

  // Each entry is a match mask: bit i set means tap i shows the current launch level.
  logic [7:0] mq[$];
  logic [7:0] cur_m  = 8'h00;
  logic       prev_l = 1'b0;
  int         toggles = 0;

  logic [7:0] plan [N];
  int e_sum, e_min, e_max, e_last;
  logic [31:0] r_sum, r_min, r_max, r_stat;

  always #5 i_clk = ~i_clk;

  x_dl_sampler #(
    .TAPS        (TAPS),
    .LOG_SAMPLES (LOGS),
    .SETTLE      (SETTLE)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_sel    (i_sel),
    .i_taps   (i_taps),
    .o_launch (o_launch),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_data   (o_data)
  );

  // Advance to the next falling edge; a new launch level picks the next mask.
  task automatic step();
    @(negedge i_clk);
    if (o_launch !== prev_l) begin
      prev_l = o_launch;
      toggles++;
      if (mq.size() > 0) cur_m = mq.pop_front();
    end
    i_taps = o_launch ? cur_m : ~cur_m;
  endtask

  function automatic int ref_code(input logic [7:0] m);
`ifdef X_DL_BUBBLE_FILTER_EN
    return $countones(m);
`else
    int n = 0;
    while (n < TAPS && m[n]) n++;
    return n;
`endif
  endfunction

  task automatic model();
    e_sum = 0; e_min = 255; e_max = 0; e_last = 0;
    for (int i = 0; i < N; i++) begin
      int c = ref_code(plan[i]);
      e_sum += c;
      if (c < e_min) e_min = c;
      if (c > e_max) e_max = c;
      e_last = c;
    end
  endtask

  task automatic read_res();
    i_sel = 2'd0; #1 r_sum  = o_data;
    i_sel = 2'd1; #1 r_min  = o_data;
    i_sel = 2'd2; #1 r_max  = o_data;
    i_sel = 2'd3; #1 r_stat = o_data;
    i_sel = 2'd0;
  endtask

  task automatic run(input int dup_at, input bit stop_after_done,
                     output int lat, output int ndone, output int tog, output logic busy1);
    for (int i = 0; i < N; i++) mq.push_back(plan[i]);
    toggles = 0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    lat = -1; ndone = 0;
    busy1 = o_busy;
    for (int k = 1; k <= 40; k++) begin
      if (o_done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (stop_after_done && lat >= 0) begin
        step();
        break;
      end
      i_start = (k == dup_at);
      step();
    end
    i_start = 1'b0;
    tog = toggles;
  endtask

  task automatic random_plan();
    for (int i = 0; i < N; i++) begin
      int c = $urandom_range(0, TAPS);
      logic [7:0] m = 8'($urandom);
      for (int j = 0; j < c; j++) m[j] = 1'b1;
      if (c < TAPS) m[c] = 1'b0;
      plan[i] = m;
    end
  endtask

  task automatic check_run(input string name, input int lat, input int ndone, input int tog);
    model();
    read_res();
    total++; if (lat !== LAT) $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); else pass_cnt++;
    total++; if (ndone !== 1) $display("FAIL %s done_count: got %0d want 1", name, ndone); else pass_cnt++;
    total++; if (tog !== N) $display("FAIL %s toggles: got %0d want %0d", name, tog, N); else pass_cnt++;
    total++; if (r_sum !== 32'(e_sum)) $display("FAIL %s sum: got %0d want %0d", name, r_sum, e_sum); else pass_cnt++;
    total++; if (r_min !== 32'(e_min)) $display("FAIL %s min: got %0d want %0d", name, r_min, e_min); else pass_cnt++;
    total++; if (r_max !== 32'(e_max)) $display("FAIL %s max: got %0d want %0d", name, r_max, e_max); else pass_cnt++;
    total++; if (r_stat !== 32'(e_last)) $display("FAIL %s stat: got %h want %h", name, r_stat, 32'(e_last)); else pass_cnt++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;
    step();
    read_res();
    total++; if (o_launch !== 1'b0) $display("FAIL reset launch: got %b want 0", o_launch); else pass_cnt++;
    total++; if (o_busy !== 1'b0) $display("FAIL reset busy: got %b want 0", o_busy); else pass_cnt++;
    total++; if (o_done !== 1'b0) $display("FAIL reset done: got %b want 0", o_done); else pass_cnt++;
    total++; if ({r_sum, r_min, r_max, r_stat} !== 128'd0)
      $display("FAIL reset data: got %h %h %h %h want all zero", r_sum, r_min, r_max, r_stat); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, nd, tg; logic b1;
    for (int i = 0; i < N; i++) plan[i] = 8'h07;
    run(0, 1'b0, lat, nd, tg, b1);
    total++; if (b1 !== 1'b1) $display("FAIL basic busy_after_start: got %b want 1", b1); else pass_cnt++;
    check_run("basic", lat, nd, tg);
    total++; if (r_sum !== 32'd12) $display("FAIL basic sum_const: got %0d want 12", r_sum); else pass_cnt++;
  endtask

  task automatic test_codes();
    int lat, nd, tg; logic b1;
    plan[0] = 8'h00; plan[1] = 8'hFF; plan[2] = 8'h1F; plan[3] = 8'h03;
    run(0, 1'b0, lat, nd, tg, b1);
    check_run("codes", lat, nd, tg);
  endtask

  task automatic test_bubble();
    int lat, nd, tg; logic b1;
    for (int i = 0; i < N; i++) plan[i] = 8'h0B;
    run(0, 1'b0, lat, nd, tg, b1);
    check_run("bubble", lat, nd, tg);
  endtask

  task automatic test_ignore_start();
    int lat, nd, tg; logic b1;
    for (int i = 0; i < N; i++) plan[i] = 8'h07;
    run(5, 1'b0, lat, nd, tg, b1);
    check_run("ignore_start", lat, nd, tg);
  endtask

  task automatic test_reset_mid();
    int lat, nd, tg, spurious; logic b1;
    for (int i = 0; i < N; i++) plan[i] = 8'h07;
    for (int i = 0; i < N; i++) mq.push_back(plan[i]);
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (9) step();
    i_rst = 1'b1; step(); i_rst = 1'b0;
    read_res();
    total++; if (o_busy !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", o_busy); else pass_cnt++;
    total++; if (o_launch !== 1'b0) $display("FAIL rst_mid launch: got %b want 0", o_launch); else pass_cnt++;
    total++; if ({r_sum, r_min, r_max, r_stat} !== 128'd0)
      $display("FAIL rst_mid data: got %h %h %h %h want all zero", r_sum, r_min, r_max, r_stat); else pass_cnt++;
    spurious = 0;
    for (int k = 0; k < 30; k++) begin
      if (o_done === 1'b1) spurious++;
      step();
    end
    total++; if (spurious !== 0) $display("FAIL rst_mid no_done: got %0d pulses want 0", spurious); else pass_cnt++;
    mq.delete();
    random_plan();
    run(0, 1'b0, lat, nd, tg, b1);
    check_run("rst_mid_fresh", lat, nd, tg);
  endtask

  task automatic test_back_to_back();
    int lat, nd, tg; logic b1; logic l0;
    random_plan();
    l0 = o_launch;
    run(0, 1'b1, lat, nd, tg, b1);
    total++; if (tg !== N) $display("FAIL b2b first_toggles: got %0d want %0d", tg, N); else pass_cnt++;
    random_plan();
    run(0, 1'b0, lat, nd, tg, b1);
    total++; if (b1 !== 1'b1) $display("FAIL b2b accepted: got busy %b want 1", b1); else pass_cnt++;
    check_run("b2b_second", lat, nd, tg);
    total++; if (o_launch !== l0) $display("FAIL b2b launch_level: got %b want %b", o_launch, l0); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, nd, tg; logic b1;
    for (int it = 0; it < 6; it++) begin
      random_plan();
      run(0, 1'b0, lat, nd, tg, b1);
      check_run($sformatf("random%0d", it), lat, nd, tg);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_sel = 2'd0; i_taps = 8'h00;
    test_reset();
    test_basic();
    test_codes();
    test_bubble();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
